// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The producer/consumer side uses master; the adder uses slave.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             busy;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  carry_out,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output carry_out,
        output busy
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-add per clock, LSB first, with a
// registered carry, valid/ready on both the operand and result sides.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] sum_q;
    logic             c_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;

    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             accept_c;
    logic             handoff_c;
    logic             last_bit_c;
    logic             s_c;
    logic             c_next_c;

    // Full-adder cell on the current LSBs of the operand shift registers.
    always_comb begin
        s_c      = ra[0] ^ rb[0] ^ c_q;
        c_next_c = (ra[0] & rb[0]) | (c_q & (ra[0] ^ rb[0]));
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        accept_c   = 1'b0;
        handoff_c  = 1'b0;
        last_bit_c = 1'b0;
        case (state)
            IDLE: begin
                accept_c = bus.in_valid;
                if (bus.in_valid) begin
                    next_state = ADD;
                end
            end
            ADD: begin
                last_bit_c = (cnt == LAST_BIT);
                if (cnt == LAST_BIT) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                handoff_c = bus.out_ready;
                if (bus.out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register; handshake flags are registered from the next state
    // so they always agree with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= next_state;
            in_ready_q  <= (next_state == IDLE);
            out_valid_q <= (next_state == DONE);
            busy_q      <= (next_state == ADD);
        end
    end

    // Serial datapath: operands shift out LSB first, sum shifts in at the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra      <= '0;
            rb      <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else if (accept_c) begin
            ra    <= bus.a;
            rb    <= bus.b;
            sum_q <= '0;
            c_q   <= 1'b0;
            cnt   <= '0;
        end else if (state == ADD) begin
            ra    <= ra >> 1;
            rb    <= rb >> 1;
            sum_q <= {s_c, sum_q[WIDTH-1:1]};
            c_q   <= c_next_c;
            cnt   <= cnt + CNT_W'(1);
            if (last_bit_c) begin
                carry_q <= c_next_c;
            end
        end
    end

    // handoff_c only moves the FSM; the result registers simply hold in DONE.
    logic unused_handoff_c;
    assign unused_handoff_c = handoff_c;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_q;
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder that accepts two operands through a valid/ready handshake and adds them LSB-first, one bit per clock, using a full-adder cell and a registered carry. It produces an N-bit sum and a carry-out through a second valid/ready handshake. It is the sequential arithmetic stage built on the team's one-bit adder cells, and it trades throughput for a single-bit datapath.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits (≥2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- in_valid  in  1  operands a/b present
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  sum/carry_out valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  (a+b) mod 2^WIDTH
- carry_out  out  1  bit WIDTH of a+b
- busy  out  1  high in ADD state

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, load shift regs ra<=a and rb<=b, clear carry reg c<=0, clear bit counter cnt<=0, clear sum shift reg, then go to ADD.
- ADD, each cycle:
  - s = ra[0]^rb[0]^c
  - c <= (ra[0]&rb[0]) | (c&(ra[0]^rb[0]))
  - ra, rb shift right by 1
  - sum reg shifts right with s inserted at MSB
  - cnt++
  - When cnt==WIDTH-1 (last bit), go to DONE. carry_out <= final carry.
- DONE: out_valid=1; sum/carry_out held stable. On out_valid&&out_ready, go to IDLE.
- in_ready=1 only in IDLE. Operands offered in ADD or DONE are not accepted and must be held by the producer.
- a/b are sampled only at the accept edge. Later changes on a/b have no effect.
- No combinational path from any input to any output. All outputs are registered or decoded from the state register.
- Counter width is clog2(WIDTH). It does not wrap in normal operation because it is reset at each accept.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, busy=0, sum=0, carry_out=0, internal carry=0, cnt=0.
- rst asserted during a clock edge overrides every other action.
- Reset mid-ADD or mid-DONE: the operation is abandoned, the state returns to IDLE, and out_valid never asserts for that operation.
- Accept at edge E0. busy is high for cycles E0..E(WIDTH-1). out_valid rises after edge E(WIDTH), i.e. WIDTH cycles after accept.
- Result handoff at edge Ek (out_valid&&out_ready) clears out_valid. in_ready rises after the same edge. The next accept is possible at Ek+1.
- Minimum issue interval is WIDTH+2 cycles.
- Backpressure: out_ready may stay low indefinitely. sum, carry_out and out_valid stay constant until the handshake.
- A transition of in_valid while in_ready=0 is ignored.
- out_ready high while out_valid=0 has no effect.
- Carry-out equals the carry out of the MSB full-add. Sum LSB corresponds to the first serial bit.

## Test plan
- Reset: hold rst 3 cycles with random inputs → in_ready=1, out_valid=0, busy=0, sum=0x00, carry_out=0. After release with in_valid=0 → remains IDLE.
- Basic add (WIDTH=8): a=0x35, b=0x4A, out_ready=1 → out_valid exactly 8 cycles after accept, sum=0x7F, carry_out=0. busy high for 8 cycles.
- Wrap/carry: a=0xFF, b=0x01 → sum=0x00, carry_out=1. Then a=0x80, b=0x80 → sum=0x00, carry_out=1. Then a=0x00, b=0x00 → sum=0x00, carry_out=0 (carry reg cleared between operations).
- Backpressure and input hold-off: a=0xFF, b=0xFF, out_ready=0 for 5 cycles after out_valid → sum=0xFE and carry_out=1 stable throughout. in_valid held high with a=0x01, b=0x02 is not accepted until after the handshake, then yields sum=0x03.
- Reset mid-operation: accept a=0x0F, b=0xF1, assert rst 3 cycles into ADD → IDLE next cycle, out_valid stays 0. A following a=0x10, b=0x20 → sum=0x30, carry_out=0.
- Random: 20 operand pairs from $random with fixed seed 47478, random out_ready stalls → every result matches {carry_out,sum}==a+b (9-bit). No result is dropped or duplicated.
